// File: rtl/stalin_sort_stream.sv
// rtl/stalin_sort_stream.sv - streaming Stalin sort: keeps the monotonic run of each frame
// The last kept element waits in H until we know whether it ends the frame.
module stalin_sort_stream #(
  parameter int WIDTH      = 8,
  parameter int SIGNED     = 0,
  parameter int DESCENDING = 0,
  parameter int STRICT     = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] kept_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {FIRST, RUN, FLUSH} state_t;

  state_t            state;
  logic [WIDTH-1:0]  h_q;
  logic [WIDTH-1:0]  r_q;
  logic              out_free;
  logic              accept;
  logic              keep;
  logic              gt;
  logic              eq;
  logic signed [WIDTH:0] x_ext;
  logic signed [WIDTH:0] r_ext;

  // One extra bit lets a single signed compare serve both signed and unsigned modes.
  always_comb begin
    x_ext = (SIGNED != 0) ? $signed({s_data[WIDTH-1], s_data}) : $signed({1'b0, s_data});
    r_ext = (SIGNED != 0) ? $signed({r_q[WIDTH-1], r_q})       : $signed({1'b0, r_q});
    gt    = x_ext > r_ext;
    eq    = x_ext == r_ext;
    if (DESCENDING != 0) keep = (STRICT != 0) ? (!gt && !eq) : !gt;
    else                 keep = (STRICT != 0) ? gt : (gt || eq);
  end

  assign out_free   = !m_valid || m_ready;
  assign s_ready    = rst_n && (state != FLUSH) && out_free;
  assign accept     = s_valid && s_ready;
  assign frame_done = m_valid && m_ready && m_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FIRST;
      h_q      <= '0;
      r_q      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      kept_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (m_ready) m_valid <= 1'b0;
      case (state)
        FIRST: if (accept) begin
          h_q      <= s_data;
          r_q      <= s_data;
          kept_cnt <= CNT_W'(1);
          drop_cnt <= '0;
          state    <= s_last ? FLUSH : RUN;
        end
        RUN: if (accept) begin
          if (keep) begin
            m_valid <= 1'b1;
            m_data  <= h_q;
            m_last  <= 1'b0;
            h_q     <= s_data;
            r_q     <= s_data;
            if (kept_cnt != '1) kept_cnt <= kept_cnt + CNT_W'(1);
            state   <= s_last ? FLUSH : RUN;
          end else begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            if (s_last) begin
              m_valid <= 1'b1;
              m_data  <= h_q;
              m_last  <= 1'b1;
              state   <= FIRST;
            end
          end
        end
        FLUSH: if (out_free) begin
          m_valid <= 1'b1;
          m_data  <= h_q;
          m_last  <= 1'b1;
          state   <= FIRST;
        end
        default: state <= FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_stalin_sort_stream.sv
// tb/tb_stalin_sort_stream.sv - directed bench over default, strict and signed-descending instances
module tb_stalin_sort_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid [3];
  logic        s_ready [3];
  logic [7:0]  s_data  [3];
  logic        s_last  [3];
  logic        m_valid [3];
  logic        m_ready [3];
  logic [7:0]  m_data  [3];
  logic        m_last  [3];
  logic [15:0] kept_cnt[3];
  logic [15:0] drop_cnt[3];
  logic        frame_done[3];

  int n_cmp = 0;
  int n_bad = 0;
  int fd [3] = '{0, 0, 0};
  logic [8:0] oq0[$];
  logic [8:0] oq1[$];
  logic [8:0] oq2[$];

  always #5 clk = ~clk;

  stalin_sort_stream u_def (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0]),
    .kept_cnt(kept_cnt[0]), .drop_cnt(drop_cnt[0]), .frame_done(frame_done[0]));

  stalin_sort_stream #(.STRICT(1)) u_strict (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1]),
    .kept_cnt(kept_cnt[1]), .drop_cnt(drop_cnt[1]), .frame_done(frame_done[1]));

  stalin_sort_stream #(.SIGNED(1), .DESCENDING(1)) u_sdesc (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]), .s_last(s_last[2]),
    .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]), .m_last(m_last[2]),
    .kept_cnt(kept_cnt[2]), .drop_cnt(drop_cnt[2]), .frame_done(frame_done[2]));

  always @(negedge clk) begin
    if (m_valid[0] && m_ready[0]) oq0.push_back({m_last[0], m_data[0]});
    if (m_valid[1] && m_ready[1]) oq1.push_back({m_last[1], m_data[1]});
    if (m_valid[2] && m_ready[2]) oq2.push_back({m_last[2], m_data[2]});
    for (int k = 0; k < 3; k++) if (frame_done[k]) fd[k]++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    int t = 0;
    s_valid[k] = 1'b1;
    s_data[k]  = d;
    s_last[k]  = l;
    @(negedge clk);
    while (!s_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_q(input int k, input string tag, input int base, input logic [8:0] e[$]);
    logic [8:0] g[$];
    case (k)
      0:       g = oq0;
      1:       g = oq1;
      default: g = oq2;
    endcase
    chk({tag, "_n"}, 32'(g.size() - base), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (base + i < g.size()) chk($sformatf("%s_%0d", tag, i), 32'(g[base + i]), 32'(e[i]));
      else                     chk($sformatf("%s_%0d", tag, i), 32'hdead, 32'(e[i]));
  endtask

  initial begin
    logic [8:0] e[$];
    int base;
    int fd_base;
    logic bad;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid[k] = 1'b0; s_data[k] = '0; s_last[k] = 1'b0; m_ready[k] = 1'b1;
    end
    #12;
    chk("rst_s_ready", 32'(s_ready[0]), 0);
    chk("rst_m_valid", 32'(m_valid[0]), 0);
    chk("rst_m_data",  32'(m_data[0]), 0);
    chk("rst_kept",    32'(kept_cnt[0]), 0);
    chk("rst_drop",    32'(drop_cnt[0]), 0);
    chk("rst_fdone",   32'(frame_done[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    base = oq0.size();
    push(0, 8'd3, 0); push(0, 8'd1, 0); push(0, 8'd4, 0);
    push(0, 8'd4, 0); push(0, 8'd2, 0); push(0, 8'd5, 1);
    drain();
    e = {9'h003, 9'h004, 9'h004, 9'h105};
    check_q(0, "asc", base, e);
    chk("asc_kept", 32'(kept_cnt[0]), 4);
    chk("asc_drop", 32'(drop_cnt[0]), 2);
    chk("asc_fdone", 32'(fd[0]), 1);

    base = oq0.size();
    push(0, 8'd9, 1);
    chk("single_flush_ready", 32'(s_ready[0]), 0);
    drain();
    e = {9'h109};
    check_q(0, "single", base, e);
    chk("single_kept", 32'(kept_cnt[0]), 1);
    chk("single_drop", 32'(drop_cnt[0]), 0);
    chk("single_fdone", 32'(fd[0]), 2);

    base = oq0.size();
    push(0, 8'd10, 0);
    push(0, 8'd20, 0);
    m_ready[0] = 1'b0;
    s_valid[0] = 1'b1; s_data[0] = 8'd30; s_last[0] = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (s_ready[0] || !m_valid[0] || m_data[0] !== 8'd10) bad = 1'b1;
    end
    chk("bp_hold", 32'(bad), 0);
    @(posedge clk); #1;
    m_ready[0] = 1'b1;
    push(0, 8'd30, 0);
    push(0, 8'd40, 1);
    drain();
    e = {9'h00a, 9'h014, 9'h01e, 9'h128};
    check_q(0, "bp", base, e);

    base = oq1.size();
    push(1, 8'd2, 0); push(1, 8'd2, 0); push(1, 8'd3, 0); push(1, 8'd1, 1);
    drain();
    e = {9'h002, 9'h103};
    check_q(1, "strict", base, e);
    chk("strict_kept", 32'(kept_cnt[1]), 2);
    chk("strict_drop", 32'(drop_cnt[1]), 2);
    chk("strict_fdone", 32'(fd[1]), 1);

    base = oq2.size();
    push(2, 8'h05, 0); push(2, 8'hff, 0); push(2, 8'h80, 0); push(2, 8'h7f, 1);
    drain();
    e = {9'h005, 9'h0ff, 9'h180};
    check_q(2, "sdesc", base, e);
    chk("sdesc_kept", 32'(kept_cnt[2]), 3);
    chk("sdesc_drop", 32'(drop_cnt[2]), 1);

    fd_base = fd[0];
    push(0, 8'd1, 0); push(0, 8'd2, 0); push(0, 8'd3, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_m_valid", 32'(m_valid[0]), 0);
    chk("mid_rst_m_data",  32'(m_data[0]), 0);
    chk("mid_rst_kept",    32'(kept_cnt[0]), 0);
    chk("mid_rst_s_ready", 32'(s_ready[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = oq0.size();
    push(0, 8'd7, 0); push(0, 8'd8, 1);
    drain();
    e = {9'h007, 9'h108};
    check_q(0, "post_rst", base, e);
    chk("post_rst_fdone", 32'(fd[0] - fd_base), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stalin_sort_stream.md
STALIN_SORT_STREAM -- requirements
Module: stalin_sort_stream

Interface
REQ-001 Parameter WIDTH, default 8, element bit width.
REQ-002 Parameter SIGNED, default 0, 1 = two's-complement compare, 0 = unsigned.
REQ-003 Parameter DESCENDING, default 0, 1 = keep non-increasing run, 0 = non-decreasing.
REQ-004 Parameter STRICT, default 0, 1 = equal values dropped, 0 = equal values kept.
REQ-005 Parameter CNT_W, default 16, width of the per-frame counters.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 s_valid  in  1  input element valid.
REQ-009 s_ready  out  1  input accept; transfer when s_valid && s_ready.
REQ-010 s_data  in  WIDTH  input element.
REQ-011 s_last  in  1  marks the final element of an input frame.
REQ-012 m_valid  out  1  output element valid (registered).
REQ-013 m_ready  in  1  downstream accept.
REQ-014 m_data  out  WIDTH  kept element (registered).
REQ-015 m_last  out  1  marks the final kept element of the frame (registered).
REQ-016 kept_cnt  out  CNT_W  kept elements in current/last frame.
REQ-017 drop_cnt  out  CNT_W  dropped elements in current/last frame.
REQ-018 frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-019 The first accepted element of every frame SHALL be kept unconditionally and become the reference R.
REQ-020 A non-first element x SHALL be kept iff: ascending x>=R (STRICT: x>R); descending x<=R (STRICT: x<R); signedness per SIGNED; kept x replaces R, dropped x leaves R unchanged.
REQ-021 The block SHALL hold the most recent kept element in hold register H and emit it to the output register only when its m_last value is known.
REQ-022 States: FIRST (no H, awaiting first element), RUN (H valid), FLUSH (emit final H with m_last=1).
REQ-023 FIRST, accept x, s_last=0 -> H=x, R=x, RUN; s_last=1 -> H=x, FLUSH.
REQ-024 RUN, kept x, s_last=0 -> output H with m_last=0, H=x, stay RUN.
REQ-025 RUN, dropped x, s_last=0 -> no output, stay RUN.
REQ-026 RUN, kept x, s_last=1 -> output H with m_last=0, H=x, FLUSH.
REQ-027 RUN, dropped x, s_last=1 -> output H with m_last=1, FIRST.
REQ-028 FLUSH -> load H into output with m_last=1 when output slot free, then FIRST.
REQ-029 s_ready SHALL equal (state != FLUSH) && (!m_valid || m_ready), combinationally.
REQ-030 The output register SHALL load only when empty or drained the same cycle; m_data/m_last SHALL stay stable while m_valid && !m_ready.
REQ-031 Latency: a kept non-final element SHALL appear on m_data one cycle after the next kept element or frame end of its frame is accepted.
REQ-032 kept_cnt/drop_cnt SHALL clear to the value of the first element of a new frame (kept_cnt=1, drop_cnt=0) and saturate at 2^CNT_W-1.
REQ-033 frame_done SHALL pulse for exactly one cycle on the handshake of the element with m_last=1; counters hold until the next frame's first accept.
REQ-034 Sustained throughput SHALL be one input per cycle with m_ready=1, except one bubble per frame ending in a kept element (FLUSH).

Reset
REQ-035 On rst_n low: state=FIRST, s_ready=0 while asserted, m_valid=0, m_data=0, m_last=0, kept_cnt=0, drop_cnt=0, frame_done=0, H and R cleared.
REQ-036 Reset mid-frame SHALL discard the partial frame without emitting m_last or frame_done.

Verification
REQ-037 Defaults, frame 3,1,4,4,2,5(last), m_ready=1 -> out 3,4,4,5, m_last on 5, kept_cnt=4, drop_cnt=2, one frame_done.
REQ-038 STRICT=1, frame 2,2,3,1(last) -> out 2,3 with m_last on 3 (emitted on dropped last), kept=2, drop=2.
REQ-039 SIGNED=1 DESCENDING=1 WIDTH=8, frame 0x05,0xFF,0x80,0x7F(last) -> out 0x05,0xFF,0x80, m_last on 0x80.
REQ-040 Single-element frame 9(last) -> FLUSH, out 9 with m_last=1, kept=1, drop=0.
REQ-041 m_ready held low 5 cycles mid-frame -> s_ready low, m_data stable, no loss/duplication after release.
REQ-042 rst_n pulsed after 3 accepted elements -> all outputs zero, next frame 7,8(last) -> out 7,8 only.
